// File: rtl/fir_coef_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fir_coef_loader                                            |
// | Description : Writer side of the FIR coefficient interface. Accepts a    |
// |               serial stream of 16-bit coefficients over valid/ready into |
// |               a shadow bank, then copies the whole bank to the active    |
// |               bank (weights_out) in a single cycle, so the filter only   |
// |               ever sees a complete coefficient set.                      |
// | Ports       : clk, rst          - clock, synchronous active-high reset   |
// |               load_start        - begin a new set (honoured in IDLE)     |
// |               coef_valid/data/last, coef_ready - beat handshake         |
// |               busy              - high while loading or committing       |
// |               commit_done       - 1-cycle pulse, new set is active       |
// |               err_len           - 1-cycle pulse, set length wrong        |
// |               weights_out       - active bank, tap 0 .. TAPS-1           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fir_coef_loader #(
    parameter int TAPS = 401
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        coef_valid,
    input  logic [15:0] coef_data,
    input  logic        coef_last,
    output logic        coef_ready,
    output logic        busy,
    output logic        commit_done,
    output logic        err_len,
    output logic [15:0] weights_out [0:TAPS-1]
);

    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(TAPS - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOAD   = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_shadow [0:TAPS-1];
    logic             w_xfer;

    // Handshake outputs are pure decodes of the state register so the
    // upstream never sees a combinational path through this block.
    assign coef_ready = (r_state == c_ST_LOAD);
    assign busy       = (r_state != c_ST_IDLE);
    assign w_xfer     = coef_valid && (r_state == c_ST_LOAD);

    // Shadow bank carries no reset: its contents only matter once a full,
    // correctly terminated set has been written into it.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_shadow[r_idx] <= coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= '0;
            commit_done <= 1'b0;
            err_len     <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                weights_out[i] <= 16'h0000;
            end
        end else begin
            commit_done <= 1'b0;
            err_len     <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (load_start) begin
                        r_idx   <= '0;
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    if (coef_valid) begin
                        if (coef_last && (r_idx == c_LAST_IDX)) begin
                            r_state <= c_ST_COMMIT;
                        end else if (coef_last || (r_idx == c_LAST_IDX)) begin
                            // Short set (last too early) or long set (no last
                            // on the final tap): abandon, active bank untouched.
                            err_len <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                c_ST_COMMIT: begin
                    weights_out <= r_shadow;
                    commit_done <= 1'b1;
                    r_state     <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_coef_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fir_coef_loader                                         |
// | Description : Self-checking bench for fir_coef_loader. Two instances     |
// |               (TAPS=4 and TAPS=401) share one stimulus bus; each phase   |
// |               checks the instance selected by r_sel against a set-level  |
// |               reference model (length rule + expected active bank).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fir_coef_loader;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        coef_valid;
    logic [15:0] coef_data;
    logic        coef_last;

    logic        rdy4, busy4, cd4, err4;
    logic        rdy401, busy401, cd401, err401;
    logic [15:0] w4   [0:3];
    logic [15:0] w401 [0:400];

    bit          r_sel;     // 0: TAPS=4 instance, 1: TAPS=401 instance
    int          n_checks;
    int          n_fail;

    logic [15:0] exp_w  [0:400];
    logic [15:0] shadow [0:400];
    logic [15:0] q_data [$];
    bit          q_last [$];

    fir_coef_loader #(.TAPS(4)) u_dut4 (
        .clk(clk), .rst(rst), .load_start(load_start), .coef_valid(coef_valid),
        .coef_data(coef_data), .coef_last(coef_last), .coef_ready(rdy4),
        .busy(busy4), .commit_done(cd4), .err_len(err4), .weights_out(w4)
    );

    fir_coef_loader #(.TAPS(401)) u_dut401 (
        .clk(clk), .rst(rst), .load_start(load_start), .coef_valid(coef_valid),
        .coef_data(coef_data), .coef_last(coef_last), .coef_ready(rdy401),
        .busy(busy401), .commit_done(cd401), .err_len(err401), .weights_out(w401)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_rdy();  return r_sel ? rdy401  : rdy4;  endfunction
    function automatic logic m_busy(); return r_sel ? busy401 : busy4; endfunction
    function automatic logic m_cd();   return r_sel ? cd401   : cd4;   endfunction
    function automatic logic m_err();  return r_sel ? err401  : err4;  endfunction
    function automatic logic [15:0] m_w(input int k);
        if (r_sel) return w401[k];
        return (k < 4) ? w4[k] : 16'h0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bank(input string tag, input int taps);
        for (int k = 0; k < taps; k++) begin
            check($sformatf("%s[%0d]", tag, k), 32'(m_w(k)), 32'(exp_w[k]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        coef_valid = 1'b0;
        load_start = 1'b0;
        coef_last = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 401; k++) exp_w[k] = 16'h0000;
    endtask

    // Plays q_data/q_last as one load. Model: the set terminates at the first
    // beat that carries last or lands on tap TAPS-1; it commits only when both
    // hold at once, otherwise it is a length error and later beats are refused.
    task automatic do_load(input int taps, input int max_gap, input int mid_start);
        int term;
        bit ok;
        int n;
        term = -1;
        ok   = 1'b0;
        n    = q_data.size();
        for (int i = 0; i < n; i++) begin
            if (term < 0 && (q_last[i] || i == taps - 1)) begin
                term = i;
                ok   = q_last[i] && (i == taps - 1);
            end
        end
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("busy_after_start", 32'(m_busy()), 32'd1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                coef_valid = 1'b0;
                tick();
            end
            coef_valid = 1'b1;
            coef_data  = q_data[i];
            coef_last  = q_last[i];
            load_start = (i == mid_start);
            check($sformatf("coef_ready_beat%0d", i), 32'(m_rdy()), 32'(i <= term));
            if (i <= term) shadow[i] = q_data[i];
            tick();
            coef_valid = 1'b0;
            coef_last  = 1'b0;
            load_start = 1'b0;
            check("bank_held_w0", 32'(m_w(0)), 32'(exp_w[0]));
            if (i > term) begin
                check("no_err_after_term", 32'(m_err()), 32'd0);
                check("no_cd_after_term", 32'(m_cd()), 32'd0);
            end
            if (i == term) begin
                if (ok) begin
                    check("commit_cycle_cd", 32'(m_cd()), 32'd0);
                    check("commit_cycle_busy", 32'(m_busy()), 32'd1);
                    check("commit_cycle_ready", 32'(m_rdy()), 32'd0);
                    tick();
                    check("commit_done", 32'(m_cd()), 32'd1);
                    check("commit_no_err", 32'(m_err()), 32'd0);
                    check("busy_after_commit", 32'(m_busy()), 32'd0);
                    for (int k = 0; k < taps; k++) exp_w[k] = shadow[k];
                    check_bank("bank_commit", taps);
                    tick();
                    check("commit_done_one_cycle", 32'(m_cd()), 32'd0);
                end else begin
                    check("err_len", 32'(m_err()), 32'd1);
                    check("err_no_cd", 32'(m_cd()), 32'd0);
                    check("err_busy", 32'(m_busy()), 32'd0);
                    check("err_ready", 32'(m_rdy()), 32'd0);
                    check_bank("bank_after_err", taps);
                    tick();
                    check("err_len_one_cycle", 32'(m_err()), 32'd0);
                end
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        r_sel      = 1'b0;
        rst        = 1'b1;
        load_start = 1'b0;
        coef_valid = 1'b0;
        coef_data  = 16'h0000;
        coef_last  = 1'b0;
        for (int k = 0; k < 401; k++) exp_w[k] = 16'h0000;

        // Reset held two cycles with random inputs.
        repeat (2) begin
            load_start = 1'($urandom);
            coef_valid = 1'($urandom);
            coef_last  = 1'($urandom);
            coef_data  = 16'($urandom);
            tick();
        end
        check("rst_ready", 32'(rdy4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_cd", 32'(cd4), 32'd0);
        check("rst_err", 32'(err4), 32'd0);
        check_bank("rst_bank4", 4);
        r_sel = 1'b1;
        check("rst_ready401", 32'(rdy401), 32'd0);
        check_bank("rst_bank401", 401);
        r_sel = 1'b0;
        rst = 1'b0;
        load_start = 1'b0;
        coef_valid = 1'b0;
        coef_last  = 1'b0;
        tick();

        // Nominal back-to-back set.
        q_data = '{16'h0001, 16'h0002, 16'h0003, 16'h8004};
        q_last = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_load(4, 0, -1);

        // Random set with stalls, then the nominal set again with stalls.
        q_data = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        do_load(4, 3, -1);
        q_data = '{16'h0001, 16'h0002, 16'h0003, 16'h8004};
        do_load(4, 3, -1);

        // Short set: last on beat 2.
        q_data = '{16'hAAAA, 16'h5555};
        q_last = '{1'b0, 1'b1};
        do_load(4, 1, -1);

        // Long set: no last by tap 3, fifth beat must be refused.
        q_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        q_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_load(4, 1, -1);

        // Random lengths and data; last (if any) only on the final beat.
        repeat (8) begin
            int n;
            n = int'($urandom_range(1, 6));
            q_data.delete();
            q_last.delete();
            for (int i = 0; i < n; i++) begin
                q_data.push_back(16'($urandom));
                q_last.push_back((i == n - 1) && ((n < 4) || 1'($urandom)));
            end
            do_load(4, 2, -1);
        end

        // TAPS=401: reset mid-load, with a load_start issued during LOAD.
        r_sel = 1'b1;
        do_reset();
        q_data = '{16'h0001, 16'h0002};
        q_last = '{1'b0, 1'b1};
        do_load(401, 0, -1);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            coef_valid = 1'b1;
            coef_data  = 16'($urandom);
            load_start = (i == 50);
            if (i % 50 == 0) check("mid_ready", 32'(m_rdy()), 32'd1);
            tick();
            check("mid_no_pulse", 32'({m_cd(), m_err()}), 32'd0);
        end
        coef_valid = 1'b0;
        load_start = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_cd", 32'(m_cd()), 32'd0);
        check("midrst_err", 32'(m_err()), 32'd0);
        check("midrst_ready", 32'(m_rdy()), 32'd0);
        check("midrst_busy", 32'(m_busy()), 32'd0);
        for (int k = 0; k < 401; k++) exp_w[k] = 16'h0000;
        check_bank("midrst_bank", 401);
        rst = 1'b0;
        tick();
        check("post_rst_no_pulse", 32'({m_cd(), m_err()}), 32'd0);

        // Full 401-beat set, beat k = k, with a load_start mid-stream.
        q_data.delete();
        q_last.delete();
        for (int k = 0; k < 401; k++) begin
            q_data.push_back(16'(k));
            q_last.push_back(k == 400);
        end
        do_load(401, 0, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
